// File: rtl/pipeline_ctrl_pkg.sv
// Shared ARM pipeline definitions: controller state encoding, NOP constant, operand match helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

  localparam int REG_W = 4;

  // Instruction loaded into a stage register when a bubble is inserted (mov r0, r0).
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } ctrl_state_e;

  // True when the instruction in ID reads register d.
  function automatic logic src_match(
    input logic [REG_W-1:0] src1,
    input logic [REG_W-1:0] src2,
    input logic             two_src,
    input logic             valid,
    input logic [REG_W-1:0] d
  );
    return valid & ((src1 == d) | (two_src & (src2 == d)));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Register-dependency hazard detector for the instruction in ID.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: fwd_en selects load-use-only checking; id_* describe the ID operands;
//        exe_*/mem_* describe the producers in EXE and MEM; hazard is the result.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);

  logic exe_match;
  logic mem_match;

  always_comb begin
    exe_match = src_match(id_src1, id_src2, id_two_src, id_valid, exe_dest);
    mem_match = src_match(id_src1, id_src2, id_two_src, id_valid, mem_dest);
    hazard    = 1'b0;
    if (fwd_en) begin
      // Forwarding covers everything except a load whose data is not back yet.
      hazard = exe_wb_en & exe_mem_r_en & exe_match;
    end else begin
      hazard = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central freeze/flush/bubble controller with data-memory timeout supervision and perf counters.
// Latency: control outputs combinational (zero cycles); mem_error and counters registered (one edge).
// Backpressure: a busy memory handshake freezes the whole pipeline until mem_ready or request drop.
// Ports: clk/rst (async active-low); hazard inputs (fwd_en, id_*, exe_*, mem_dest/mem_wb_en);
//        branch_taken; mem_req/mem_ready handshake; freeze_front, bubble_id, freeze_back, flush;
//        mem_error sticky flag; stall_cnt/flush_cnt saturating counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             bubble_id,
  output logic             freeze_back,
  output logic             flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Last wait_cnt value at which one more busy edge is still tolerated.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  ctrl_state_e      state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             busy;
  logic             hazard;

  hazard_detect u_hazard (
    .fwd_en       (fwd_en),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_valid     (id_valid),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard)
  );

  assign busy = mem_req & ~mem_ready;

  // Memory wait supervision.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (busy) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_WAIT: begin
        if (busy) begin
          if (wait_cnt_q == TIMEOUT_LAST) begin
            state_d = ST_ERROR;
          end
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          // Ready or request withdrawn: the next request is a fresh access.
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
        end
      end
      ST_ERROR: begin
        // Absorbing until reset.
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // Pipeline controls, highest priority first. A taken branch during a busy
  // access stays parked in EXE and is flushed in the ready cycle.
  always_comb begin
    freeze_front = 1'b0;
    freeze_back  = 1'b0;
    flush        = 1'b0;
    bubble_id    = 1'b0;
    if ((state_q == ST_ERROR) || busy) begin
      freeze_front = 1'b1;
      freeze_back  = 1'b1;
    end else if (branch_taken) begin
      // The ID instruction is squashed, so any hazard it carries is moot.
      flush = 1'b1;
    end else if (hazard) begin
      freeze_front = 1'b1;
      bubble_id    = 1'b1;
    end
  end

  // Sticky error flag and saturating counters.
  always_comb begin
    mem_error_d = mem_error_q | (state_d == ST_ERROR);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze_front && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 8'd0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_error = mem_error_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall controller for the five-stage ARM pipeline. It drives the `freeze`, `flush` and bubble controls that the IF, ID, EXE and MEM stage registers consume, from three sources:

- register dependencies seen in ID,
- taken branches resolved in EXE,
- a multi-cycle data-memory handshake in MEM.

It also supervises memory latency with a timeout and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: number of consecutive busy memory cycles before a fatal error; legal range 2..255.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fwd_en`  in  1  forwarding unit present/enabled.
- `id_src1`, `id_src2`  in  4 each  source registers of the instruction in ID.
- `id_two_src`  in  1  `id_src2` is a real operand.
- `id_valid`  in  1  ID holds a real instruction (not a bubble).
- `exe_dest`  in  4  destination register of the instruction in EXE.
- `exe_wb_en`  in  1  write-back enable of the instruction in EXE.
- `exe_mem_r_en`  in  1  the instruction in EXE is a load.
- `mem_dest`  in  4  destination register of the instruction in MEM.
- `mem_wb_en`  in  1  write-back enable of the instruction in MEM.
- `branch_taken`  in  1  the branch in EXE is taken.
- `mem_req`  in  1  MEM stage is accessing data memory (level).
- `mem_ready`  in  1  data memory completes the access this cycle.
- `freeze_front`  out  1  hold the PC and the IF/ID register.
- `bubble_id`  out  1  load a NOP into the ID/EXE register.
- `freeze_back`  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers.
- `flush`  out  1  clear the IF/ID and ID/EXE registers.
- `mem_error`  out  1  sticky memory-timeout flag.
- `stall_cnt`  out  `CNT_W`  saturating count of cycles with `freeze_front`=1.
- `flush_cnt`  out  `CNT_W`  saturating count of cycles with `flush`=1.

## Operation
Derived signals:
- `busy` = `mem_req` & ~`mem_ready`.
- Source match `m(d)` = (`id_src1`==`d`) | (`id_two_src` & `id_src2`==`d`), qualified by `id_valid`.
- Hazard:
  - `fwd_en`=1: `hazard` = `exe_wb_en` & `exe_mem_r_en` & `m(exe_dest)` (load-use only).
  - `fwd_en`=0: `hazard` = (`exe_wb_en` & `m(exe_dest)`) | (`mem_wb_en` & `m(mem_dest)`).

FSM states: IDLE, WAIT, ERROR.
- IDLE → WAIT on an edge with `busy`=1; `wait_cnt`←1.
- WAIT:
  - `busy`=1: `wait_cnt` increments.
  - `busy`=1 and `wait_cnt`==`MEM_TIMEOUT`-1: go to ERROR.
  - `mem_ready`=1 or `mem_req`=0: go to IDLE, `wait_cnt`←0.
- ERROR is absorbing until reset; `mem_error`=1.

Output priority, highest first:
1. ERROR state: `freeze_front`=`freeze_back`=1; `flush`=0, `bubble_id`=0.
2. `busy`=1: `freeze_front`=`freeze_back`=1; `flush`=0, `bubble_id`=0. A taken branch stays held in EXE and is flushed in the ready cycle.
3. `branch_taken`=1: `flush`=1, `freeze_front`=0, `bubble_id`=0. Any hazard in ID is ignored because that instruction is squashed.
4. `hazard`=1: `freeze_front`=1, `bubble_id`=1.
5. Otherwise all control outputs are 0.

Counters:
- Increment by 1 per qualifying cycle.
- Hold at all-ones; no wrap.
- Continue counting in ERROR (`stall_cnt` only).

## Timing
- `freeze_front`, `freeze_back`, `flush`, `bubble_id` are combinational from the inputs and the state, with zero latency; they must be valid before the same edge they act on.
- `mem_error`, `stall_cnt`, `flush_cnt` are registered and update one edge after the qualifying cycle.
- A `mem_ready` asserted in the first request cycle gives zero stall cycles; the FSM never leaves IDLE.
- Timeout: `mem_error` rises after the `MEM_TIMEOUT`-th consecutive busy edge.
- A new `mem_req` in the cycle after `mem_ready` is a new access, and its `wait_cnt` restarts at 1.
- Reset values: state=IDLE, `wait_cnt`=0, `mem_error`=0, both counters 0.
- With `mem_req`=`branch_taken`=0 after reset, all control outputs are 0.
- Reset asserted mid-WAIT or in ERROR returns immediately (asynchronously) to IDLE.

## Structure
- The state encoding (IDLE=2'd0, WAIT=2'd1, ERROR=2'd2) and the NOP/bubble constant go in the shared ARM defines package.
- The hazard equation is a natural combinational sub-module, `hazard_detect`, reusable by the forwarding unit.
- The FSM, the timeout counter and the performance counters stay in `pipeline_ctrl`.

## Test plan
- Load-use hazard: `fwd_en`=1, `exe_mem_r_en`=`exe_wb_en`=1, `exe_dest`=3, `id_src1`=3 → one cycle with `freeze_front`=`bubble_id`=1, and `stall_cnt`=1. With `fwd_en`=1 and a non-load in EXE there is no stall.
- No forwarding: `fwd_en`=0, `mem_wb_en`=1, `mem_dest`=5, `id_two_src`=1, `id_src2`=5 → stall. The same case with `id_two_src`=0 → no stall.
- Branch with hazard: `branch_taken`=1 and `hazard`=1 together → `flush`=1, `freeze_front`=0, `bubble_id`=0, and `flush_cnt` increments.
- Memory wait plus branch: `mem_req`=1 with `mem_ready` low for 3 cycles, `branch_taken`=1 throughout → `freeze_back`=1 and `flush`=0 for 3 cycles, then `flush`=1 in the ready cycle.
- Timeout: `MEM_TIMEOUT`=4, `mem_req`=1, `mem_ready`=0 → `mem_error`=1 after the 4th edge, and freezes hold even after `mem_ready` later rises. Asserting `rst`=0 clears everything.
- Counter saturation: `CNT_W`=4 with 20 stall cycles → `stall_cnt`=15.
